tt_spi_uio_ctrl: RTL and testbench

- SPI-mode-0 slave register block that drives the bidirectional user IOs of the top-level tile.
- Sits directly downstream of the dedicated input pins and directly upstream of the uio_out/uio_oe outputs; the top-level drives these two buses from this block instead of tying them to ground.
- The host writes the output value and the output-enable mask over SPI, and can read back the same registers plus the live uio_in pins and an ID byte.
- All SPI pins are oversampled by the system clock.

---
 rtl/tt_spi_uio_ctrl_pkg.sv | 23 ++
 rtl/tt_spi_uio_ctrl_pin_sync.sv | 41 ++++
 rtl/tt_spi_uio_ctrl.sv | 134 +++++++++++++
 tb/tb_tt_spi_uio_ctrl.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/tt_spi_uio_ctrl_pkg.sv
// Shared constants and types for the SPI-controlled user-IO register block.
package tt_spi_uio_ctrl_pkg;

  localparam int FRAME_BITS = 16;
  localparam int CNT_W      = 5;

  localparam logic [6:0] ADDR_OUT = 7'd0;
  localparam logic [6:0] ADDR_OE  = 7'd1;
  localparam logic [6:0] ADDR_IN  = 7'd2;
  localparam logic [6:0] ADDR_ID  = 7'd3;

  // Counter values at which the frame reaches its command/data boundary and its end.
  localparam logic [CNT_W-1:0] CMD_LAST_BIT = CNT_W'(FRAME_BITS / 2 - 1);
  localparam logic [CNT_W-1:0] TX_FIRST     = CNT_W'(FRAME_BITS / 2);
  localparam logic [CNT_W-1:0] LAST_BIT     = CNT_W'(FRAME_BITS - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

endpackage

// File: rtl/tt_spi_uio_ctrl_pin_sync.sv
// Multi-flop synchroniser for one asynchronous SPI pin, with rise/fall detect
// against a one-cycle-delayed copy of the synchronised level.
module spi_pin_sync #(
  parameter int   STAGES = 2,
  parameter logic INIT   = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pin,
  output logic sync,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] stage_reg;
  logic [STAGES-1:0] stage_next;
  logic              dly_reg;

  for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
    if (gi == 0) begin : g_first
      assign stage_next[gi] = pin;
    end else begin : g_chain
      assign stage_next[gi] = stage_reg[gi-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_reg <= {STAGES{INIT}};
      dly_reg   <= INIT;
    end else begin
      stage_reg <= stage_next;
      dly_reg   <= stage_reg[STAGES-1];
    end
  end

  assign sync = stage_reg[STAGES-1];
  assign rise = sync & ~dly_reg;
  assign fall = ~sync & dly_reg;

endmodule

// File: rtl/tt_spi_uio_ctrl.sv
// SPI mode-0 slave driving uio_out/uio_oe. Define SPI_READBACK_EN to build the
// MISO read path (register readback, live uio_in and ID byte).
module tt_spi_uio_ctrl
  import tt_spi_uio_ctrl_pkg::*;
#(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] ID_VALUE    = 8'hA5,
  parameter logic [7:0] RESET_OUT   = 8'h00,
  parameter logic [7:0] RESET_OE    = 8'h00
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       spi_sclk,
  input  logic       spi_cs_n,
  input  logic       spi_mosi,
  output logic       spi_miso,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  logic sclk_s_unused, sclk_rise, sclk_fall;
  logic cs_s, cs_rise_unused, cs_fall_unused;
  logic mosi_s, mosi_rise_unused, mosi_fall_unused;

  spi_pin_sync #(.STAGES(SYNC_STAGES), .INIT(1'b0)) u_sclk_sync (
    .clk(clk), .rst_n(rst_n), .pin(spi_sclk),
    .sync(sclk_s_unused), .rise(sclk_rise), .fall(sclk_fall)
  );
  spi_pin_sync #(.STAGES(SYNC_STAGES), .INIT(1'b1)) u_cs_sync (
    .clk(clk), .rst_n(rst_n), .pin(spi_cs_n),
    .sync(cs_s), .rise(cs_rise_unused), .fall(cs_fall_unused)
  );
  spi_pin_sync #(.STAGES(SYNC_STAGES), .INIT(1'b0)) u_mosi_sync (
    .clk(clk), .rst_n(rst_n), .pin(spi_mosi),
    .sync(mosi_s), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
  );

  state_t                  state_reg;
  logic [CNT_W-1:0]        cnt_reg;
  // Only 15 bits are stored: the final bit is consumed straight from mosi_s.
  logic [FRAME_BITS-2:0]   shift_reg;
  logic [FRAME_BITS-1:0]   frame_next;
  logic [7:0]              out_reg, oe_reg;

  assign frame_next = {shift_reg, mosi_s};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      shift_reg <= '0;
      out_reg   <= RESET_OUT;
      oe_reg    <= RESET_OE;
    end else begin
      case (state_reg)
        IDLE: begin
          if (!cs_s) begin
            cnt_reg   <= '0;
            state_reg <= SHIFT;
          end
        end
        SHIFT: begin
          if (sclk_rise) begin
            shift_reg <= frame_next[FRAME_BITS-2:0];
            cnt_reg   <= cnt_reg + CNT_W'(1);
            if (cnt_reg == LAST_BIT) begin
              state_reg <= DONE;
              if (frame_next[15]) begin
                case (frame_next[14:8])
                  ADDR_OUT: out_reg <= frame_next[7:0];
                  ADDR_OE:  oe_reg  <= frame_next[7:0];
                  default:  ;
                endcase
              end
            end
          end
        end
        DONE:    ;
        default: state_reg <= IDLE;
      endcase
      // Deselect wins over everything except a commit landing on the same edge.
      if (cs_s) state_reg <= IDLE;
    end
  end

  assign uio_out = out_reg;
  assign uio_oe  = oe_reg;

`ifdef SPI_READBACK_EN
  logic [7:0] in_meta_reg, in_sync_reg, tx_reg, rd_data;
  logic       miso_reg;

  // At the 8th rise frame_next[7:0] holds {W, A}.
  always_comb begin
    rd_data = 8'h00;
    case (frame_next[6:0])
      ADDR_OUT: rd_data = out_reg;
      ADDR_OE:  rd_data = oe_reg;
      ADDR_IN:  rd_data = in_sync_reg;
      ADDR_ID:  rd_data = ID_VALUE;
      default:  rd_data = 8'h00;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_meta_reg <= '0;
      in_sync_reg <= '0;
      tx_reg      <= '0;
      miso_reg    <= 1'b0;
    end else begin
      in_meta_reg <= uio_in;
      in_sync_reg <= in_meta_reg;
      if (cs_s || state_reg != SHIFT) begin
        miso_reg <= 1'b0;
      end else if (sclk_rise) begin
        if (cnt_reg == CMD_LAST_BIT) tx_reg <= frame_next[7] ? 8'h00 : rd_data;
        if (cnt_reg == LAST_BIT) miso_reg <= 1'b0;
      end else if (sclk_fall && cnt_reg >= TX_FIRST) begin
        miso_reg <= tx_reg[7];
        tx_reg   <= {tx_reg[6:0], 1'b0};
      end
    end
  end

  assign spi_miso = miso_reg;
`else
  logic read_path_unused;
  assign read_path_unused = ^{uio_in, sclk_fall};
  assign spi_miso = 1'b0;
`endif

endmodule

// File: tb/tb_tt_spi_uio_ctrl.sv
// Directed table-driven bench for tt_spi_uio_ctrl (with or without SPI_READBACK_EN).
module tb_tt_spi_uio_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       spi_sclk = 1'b0;
  logic       spi_cs_n = 1'b1;
  logic       spi_mosi = 1'b0;
  logic       spi_miso;
  logic [7:0] uio_in = 8'h00;
  logic [7:0] uio_out, uio_oe;

`ifdef SPI_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  tt_spi_uio_ctrl dut (
    .clk(clk), .rst_n(rst_n), .spi_sclk(spi_sclk), .spi_cs_n(spi_cs_n),
    .spi_mosi(spi_mosi), .spi_miso(spi_miso), .uio_in(uio_in),
    .uio_out(uio_out), .uio_oe(uio_oe)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] frame;
    int          nbits;
    logic [7:0]  uin;
    logic [7:0]  exp_out;
    logic [7:0]  exp_oe;
    logic [15:0] exp_miso;
  } vec_t;

  localparam int NV = 14;
  vec_t vecs [NV];

  int n_checks = 0;
  int n_pass   = 0;

  logic [15:0] cap_miso;
  logic [7:0]  lat_out, lat_oe;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Mode-0 frame: MOSI set while sclk low, host samples MISO at each rise.
  // Register state is snapshotted SYNC_STAGES+1 clk edges after the last rise.
  task automatic spi_frame(input logic [15:0] word, input int nbits);
    cap_miso = 16'h0000;
    spi_cs_n = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      spi_mosi = word[15-i];
      repeat (4) @(negedge clk);
      spi_sclk = 1'b1;
      cap_miso[15-i] = spi_miso;
      if (i == 15) begin
        repeat (3) @(posedge clk);
        #1;
        lat_out = uio_out;
        lat_oe  = uio_oe;
        repeat (2) @(negedge clk);
      end else begin
        repeat (4) @(negedge clk);
      end
      spi_sclk = 1'b0;
    end
    repeat (4) @(negedge clk);
    spi_cs_n = 1'b1;
    spi_mosi = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  initial begin
    vecs[0]  = '{16'h81F0, 16, 8'h00, 8'h00, 8'hF0, 16'h0000};
    vecs[1]  = '{16'h80AA, 16, 8'h00, 8'hAA, 8'hF0, 16'h0000};
    vecs[2]  = '{16'h80FF, 12, 8'h00, 8'hAA, 8'hF0, 16'h0000};
    vecs[3]  = '{16'h8011, 16, 8'h00, 8'h11, 8'hF0, 16'h0000};
    vecs[4]  = '{16'h8577, 16, 8'h00, 8'h11, 8'hF0, 16'h0000};
    vecs[5]  = '{16'h8277, 16, 8'h00, 8'h11, 8'hF0, 16'h0000};
    vecs[6]  = '{16'h8377, 16, 8'h00, 8'h11, 8'hF0, 16'h0000};
    vecs[7]  = '{16'h803C, 16, 8'h00, 8'h3C, 8'hF0, 16'h0000};
    vecs[8]  = '{16'h0000, 16, 8'h00, 8'h3C, 8'hF0, RB ? 16'h003C : 16'h0000};
    vecs[9]  = '{16'h0300, 16, 8'h00, 8'h3C, 8'hF0, RB ? 16'h00A5 : 16'h0000};
    vecs[10] = '{16'h0200, 16, 8'h5A, 8'h3C, 8'hF0, RB ? 16'h005A : 16'h0000};
    vecs[11] = '{16'h0500, 16, 8'h5A, 8'h3C, 8'hF0, 16'h0000};
    vecs[12] = '{16'h0100, 16, 8'h00, 8'h3C, 8'hF0, RB ? 16'h00F0 : 16'h0000};
    vecs[13] = '{16'h8099, 16, 8'h00, 8'h99, 8'hF0, 16'h0000};

    // Reset state
    repeat (3) @(negedge clk);
    check("reset_out", {8'h00, uio_out}, 16'h0000);
    check("reset_oe", {8'h00, uio_oe}, 16'h0000);
    check("reset_miso", {15'h0, spi_miso}, 16'h0000);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    for (int v = 0; v < NV; v++) begin
      uio_in = vecs[v].uin;
      repeat (4) @(negedge clk);
      spi_frame(vecs[v].frame, vecs[v].nbits);
      if (vecs[v].nbits == 16) begin
        check("commit_out", {8'h00, lat_out}, {8'h00, vecs[v].exp_out});
        check("commit_oe", {8'h00, lat_oe}, {8'h00, vecs[v].exp_oe});
      end else begin
        check("abort_out", {8'h00, uio_out}, {8'h00, vecs[v].exp_out});
        check("abort_oe", {8'h00, uio_oe}, {8'h00, vecs[v].exp_oe});
      end
      check("miso_word", cap_miso, vecs[v].exp_miso);
      $display("txn %0d frame=%h bits=%0d uio_out=%h uio_oe=%h miso=%h",
               v, vecs[v].frame, vecs[v].nbits, uio_out, uio_oe, cap_miso);
    end

    // Reset in the middle of a frame clears registers immediately.
    spi_cs_n = 1'b0;
    for (int i = 0; i < 5; i++) begin
      spi_mosi = (i == 0);
      repeat (4) @(negedge clk);
      spi_sclk = 1'b1;
      repeat (4) @(negedge clk);
      spi_sclk = 1'b0;
    end
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_out", {8'h00, uio_out}, 16'h0000);
    check("midrst_oe", {8'h00, uio_oe}, 16'h0000);
    check("midrst_miso", {15'h0, spi_miso}, 16'h0000);
    spi_cs_n = 1'b1;
    spi_mosi = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    spi_frame(16'h8042, 16);
    check("postrst_out", {8'h00, lat_out}, 16'h0042);
    check("postrst_oe", {8'h00, lat_oe}, 16'h0000);
    $display("txn reset frame=8042 uio_out=%h uio_oe=%h", uio_out, uio_oe);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
